// File: rtl/apb2axi_pkg.sv
// Shared parameters and the buffered-beat type for the APB-to-AXI bridge read-data path.
package apb2axi_pkg;

    localparam int TAG_W      = 3;
    localparam int APB_DATA_W = 32;
    localparam int RDF_DEPTH  = 16;

    typedef struct packed {
        logic                  last;
        logic [APB_DATA_W-1:0] data;
    } rdf_entry_t;

endpackage

// File: rtl/apb2axi_rdf_ptr.sv
// Write pointer, read pointer and occupancy for one tag queue of the read-data buffer.
module apb2axi_rdf_ptr
    import apb2axi_pkg::*;
#(
    parameter int DEPTH = RDF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign full   = (count_q == (PTR_W+1)'(DEPTH));
    assign empty  = (count_q == {(PTR_W+1){1'b0}});

endmodule

// File: rtl/apb2axi_rdf.sv
// Per-tag read-data FIFOs between the AXI R path and the APB register block.
// Optional APB2AXI_RDF_CHK_EN adds sticky err_ovf / err_req outputs and simulation messages.
module apb2axi_rdf
    import apb2axi_pkg::rdf_entry_t;
#(
    parameter int TAG_W      = apb2axi_pkg::TAG_W,
    parameter int APB_DATA_W = apb2axi_pkg::APB_DATA_W,
    parameter int RDF_DEPTH  = apb2axi_pkg::RDF_DEPTH
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [APB_DATA_W-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  rdf_data_req,
    input  logic [TAG_W-1:0]      rdf_data_req_tag,
    output logic                  rdf_data_valid,
    input  logic                  rdf_data_ready,
    output logic [APB_DATA_W-1:0] rdf_data_out,
    output logic                  rdf_data_last,
    output logic [(2**TAG_W)*($clog2(RDF_DEPTH)+1)-1:0] tag_count
`ifdef APB2AXI_RDF_CHK_EN
    ,
    output logic                  err_ovf,
    output logic                  err_req
`endif
);

    localparam int NUM_TAGS = 2**TAG_W;
    localparam int PTR_W    = $clog2(RDF_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2
    } rd_state_e;

    rd_state_e             state_q, state_d;
    logic [TAG_W-1:0]      cur_tag_q, cur_tag_d;
    logic                  valid_q, valid_d;
    logic [APB_DATA_W-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;

    rdf_entry_t            mem_q [NUM_TAGS*RDF_DEPTH];
    rdf_entry_t            head_s;

    logic [PTR_W-1:0]      wr_ptr_s [NUM_TAGS];
    logic [PTR_W-1:0]      rd_ptr_s [NUM_TAGS];
    logic [CNT_W-1:0]      count_s  [NUM_TAGS];
    logic [NUM_TAGS-1:0]   full_s;
    logic [NUM_TAGS-1:0]   empty_s;
    logic [NUM_TAGS-1:0]   push_s;
    logic [NUM_TAGS-1:0]   pop_s;
    logic                  wr_fire_s;
    logic                  pop_fire_s;

    assign wr_ready   = ~full_s[wr_tag];
    assign wr_fire_s  = wr_valid & wr_ready;
    assign pop_fire_s = (state_q == S_PRESENT) & rdf_data_ready;

    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag
        assign push_s[g] = wr_fire_s  & (wr_tag    == TAG_W'(g));
        assign pop_s[g]  = pop_fire_s & (cur_tag_q == TAG_W'(g));

        apb2axi_rdf_ptr #(
            .DEPTH (RDF_DEPTH),
            .PTR_W (PTR_W)
        ) u_ptr (
            .pclk    (pclk),
            .presetn (presetn),
            .push    (push_s[g]),
            .pop     (pop_s[g]),
            .wr_ptr  (wr_ptr_s[g]),
            .rd_ptr  (rd_ptr_s[g]),
            .count   (count_s[g]),
            .full    (full_s[g]),
            .empty   (empty_s[g])
        );

        assign tag_count[g*CNT_W +: CNT_W] = count_s[g];
    end

    // Beat storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge pclk) begin
        if (wr_fire_s) begin
            mem_q[{wr_tag, wr_ptr_s[wr_tag]}] <= '{last: wr_last, data: wr_data};
        end
    end

    assign head_s = mem_q[{cur_tag_q, rd_ptr_s[cur_tag_q]}];

    // Read FSM state register, including the latched tag.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= S_IDLE;
            cur_tag_q <= {TAG_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cur_tag_q <= cur_tag_d;
        end
    end

    // Read FSM next state; requests outside S_IDLE are dropped.
    always_comb begin
        state_d   = state_q;
        cur_tag_d = cur_tag_q;
        case (state_q)
            S_IDLE: begin
                if (rdf_data_req) begin
                    state_d   = S_WAIT;
                    cur_tag_d = rdf_data_req_tag;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!empty_s[cur_tag_q]) begin
                    state_d = S_PRESENT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_PRESENT: begin
                if (rdf_data_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PRESENT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read FSM outputs: capture the queue head on entry to S_PRESENT.
    always_comb begin
        valid_d    = valid_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        case (state_q)
            S_WAIT: begin
                if (!empty_s[cur_tag_q]) begin
                    valid_d    = 1'b1;
                    out_data_d = head_s.data;
                    out_last_d = head_s.last;
                end else begin
                    valid_d    = 1'b0;
                end
            end
            S_PRESENT: begin
                if (rdf_data_ready) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: valid_d = 1'b0;
        endcase
    end

    // Registered presentation outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            valid_q    <= 1'b0;
            out_data_q <= {APB_DATA_W{1'b0}};
            out_last_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

    assign rdf_data_valid = valid_q;
    assign rdf_data_out   = out_data_q;
    assign rdf_data_last  = out_last_q;

`ifdef APB2AXI_RDF_CHK_EN
    logic err_ovf_q, err_ovf_d;
    logic err_req_q, err_req_d;

    // Sticky protocol errors: upstream pushing into a full queue, or a request while busy.
    always_comb begin
        err_ovf_d = err_ovf_q | (wr_valid & ~wr_ready);
        err_req_d = err_req_q | (rdf_data_req & (state_q != S_IDLE));
    end

    // Error flag registers, cleared only by reset.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            err_ovf_q <= 1'b0;
            err_req_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_req_q <= err_req_d;
        end
    end

    // Simulation messages for the same two conditions.
    always_ff @(posedge pclk) begin
        if (presetn && wr_valid && !wr_ready) begin
            $error("apb2axi_rdf: write to full tag %0d", wr_tag);
        end
        if (presetn && rdf_data_req && (state_q != S_IDLE)) begin
            $error("apb2axi_rdf: data request while busy on tag %0d", cur_tag_q);
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_req = err_req_q;
`endif

endmodule

// File: tb/tb_apb2axi_rdf.sv
// Directed bench for apb2axi_rdf: ordering, tag isolation, wait-on-empty, full/wrap, hold and reset.
module tb_apb2axi_rdf;
    import apb2axi_pkg::*;

    localparam int CNT_W    = $clog2(RDF_DEPTH) + 1;
    localparam int NUM_TAGS = 2**TAG_W;

    logic                      pclk = 1'b0;
    logic                      presetn;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [TAG_W-1:0]          wr_tag;
    logic [APB_DATA_W-1:0]     wr_data;
    logic                      wr_last;
    logic                      rdf_data_req;
    logic [TAG_W-1:0]          rdf_data_req_tag;
    logic                      rdf_data_valid;
    logic                      rdf_data_ready;
    logic [APB_DATA_W-1:0]     rdf_data_out;
    logic                      rdf_data_last;
    logic [NUM_TAGS*CNT_W-1:0] tag_count;
`ifdef APB2AXI_RDF_CHK_EN
    logic                      err_ovf;
    logic                      err_req;
`endif

    int n_vec = 0;
    int n_err = 0;

    apb2axi_rdf dut (
        .pclk             (pclk),
        .presetn          (presetn),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_tag           (wr_tag),
        .wr_data          (wr_data),
        .wr_last          (wr_last),
        .rdf_data_req     (rdf_data_req),
        .rdf_data_req_tag (rdf_data_req_tag),
        .rdf_data_valid   (rdf_data_valid),
        .rdf_data_ready   (rdf_data_ready),
        .rdf_data_out     (rdf_data_out),
        .rdf_data_last    (rdf_data_last),
        .tag_count        (tag_count)
`ifdef APB2AXI_RDF_CHK_EN
        ,
        .err_ovf          (err_ovf),
        .err_req          (err_req)
`endif
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int t);
        return tag_count[t*CNT_W +: CNT_W];
    endfunction

    // One-cycle write, driven from a falling edge; returns on the falling edge after acceptance.
    task automatic write_beat(input logic [TAG_W-1:0] tag, input logic [APB_DATA_W-1:0] d,
                              input logic l);
        wr_valid = 1'b1;
        wr_tag   = tag;
        wr_data  = d;
        wr_last  = l;
        @(negedge pclk);
        wr_valid = 1'b0;
    endtask

    // Request, expect valid exactly two edges later, then pop (optionally writing the same cycle).
    task automatic pop_beat(input logic [TAG_W-1:0] tag, input logic [APB_DATA_W-1:0] ed,
                            input logic el, input string nm,
                            input logic do_wr = 1'b0, input logic [APB_DATA_W-1:0] wd = '0);
        rdf_data_req     = 1'b1;
        rdf_data_req_tag = tag;
        @(negedge pclk);
        rdf_data_req = 1'b0;
        check_eq({nm, "_wait_valid"}, 64'(rdf_data_valid), 64'd0);
        @(negedge pclk);
        check_eq({nm, "_valid"}, 64'(rdf_data_valid), 64'd1);
        check_eq({nm, "_data"}, 64'(rdf_data_out), 64'(ed));
        check_eq({nm, "_last"}, 64'(rdf_data_last), 64'(el));
        rdf_data_ready = 1'b1;
        if (do_wr) begin
            wr_valid = 1'b1;
            wr_tag   = tag;
            wr_data  = wd;
            wr_last  = wd[0];
        end
        @(negedge pclk);
        rdf_data_ready = 1'b0;
        wr_valid       = 1'b0;
        check_eq({nm, "_popped"}, 64'(rdf_data_valid), 64'd0);
    endtask

    initial begin
        logic [APB_DATA_W-1:0] q[$];
        logic [APB_DATA_W-1:0] d;

        presetn          = 1'b0;
        wr_valid         = 1'b0;
        wr_tag           = '0;
        wr_data          = '0;
        wr_last          = 1'b0;
        rdf_data_req     = 1'b0;
        rdf_data_req_tag = '0;
        rdf_data_ready   = 1'b0;
        repeat (2) @(negedge pclk);
        check_eq("rst_valid", 64'(rdf_data_valid), 64'd0);
        check_eq("rst_data", 64'(rdf_data_out), 64'd0);
        check_eq("rst_last", 64'(rdf_data_last), 64'd0);
        check_eq("rst_count", 64'(tag_count), 64'd0);
        check_eq("rst_wr_ready", 64'(wr_ready), 64'd1);
        presetn = 1'b1;
        @(negedge pclk);

        // In-order drain of one tag, last flag only on the final beat.
        write_beat(3'd3, 32'h11, 1'b0);
        write_beat(3'd3, 32'h22, 1'b0);
        write_beat(3'd3, 32'h33, 1'b0);
        write_beat(3'd3, 32'h44, 1'b1);
        check_eq("t1_count4", 64'(cnt_of(3)), 64'd4);
        pop_beat(3'd3, 32'h11, 1'b0, "t1_b0");
        pop_beat(3'd3, 32'h22, 1'b0, "t1_b1");
        pop_beat(3'd3, 32'h33, 1'b0, "t1_b2");
        pop_beat(3'd3, 32'h44, 1'b1, "t1_b3");
        check_eq("t1_count0", 64'(cnt_of(3)), 64'd0);

        // Interleaved tags drain independently.
        write_beat(3'd1, 32'hA1, 1'b0);
        write_beat(3'd2, 32'hB1, 1'b0);
        write_beat(3'd1, 32'hA2, 1'b1);
        write_beat(3'd2, 32'hB2, 1'b1);
        pop_beat(3'd2, 32'hB1, 1'b0, "t2_b1");
        pop_beat(3'd2, 32'hB2, 1'b1, "t2_b2");
        check_eq("t2_tag1_untouched", 64'(cnt_of(1)), 64'd2);
        pop_beat(3'd1, 32'hA1, 1'b0, "t2_a1");
        pop_beat(3'd1, 32'hA2, 1'b1, "t2_a2");
        check_eq("t2_all_empty", 64'(tag_count), 64'd0);

        // Waiting on an empty tag; a write releases it one edge after acceptance.
        rdf_data_req     = 1'b1;
        rdf_data_req_tag = 3'd5;
        @(negedge pclk);
        rdf_data_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq("t3_empty_wait", 64'(rdf_data_valid), 64'd0);
            @(negedge pclk);
        end
        write_beat(3'd5, 32'hDEAD, 1'b0);
        check_eq("t3_not_early", 64'(rdf_data_valid), 64'd0);
        @(negedge pclk);
        check_eq("t3_valid", 64'(rdf_data_valid), 64'd1);
        check_eq("t3_data", 64'(rdf_data_out), 64'hDEAD);
        rdf_data_ready = 1'b1;
        @(negedge pclk);
        rdf_data_ready = 1'b0;
        check_eq("t3_count0", 64'(cnt_of(5)), 64'd0);

        // Fill tag 0, then pop+write in the same cycle until both pointers wrap several times.
        for (int i = 0; i < RDF_DEPTH; i++) begin
            write_beat(3'd0, APB_DATA_W'(i), i[0]);
            q.push_back(APB_DATA_W'(i));
        end
        check_eq("t4_full_count", 64'(cnt_of(0)), 64'(RDF_DEPTH));
        wr_tag = 3'd0;
        #1;
        check_eq("t4_ready_tag0", 64'(wr_ready), 64'd0);
        wr_tag = 3'd1;
        #1;
        check_eq("t4_ready_tag1", 64'(wr_ready), 64'd1);
        @(negedge pclk);
        d = q.pop_front();
        pop_beat(3'd0, d, d[0], "t4_first");
        check_eq("t4_count_after_first", 64'(cnt_of(0)), 64'(RDF_DEPTH - 1));
        for (int k = 0; k < 3 * RDF_DEPTH; k++) begin
            d = q.pop_front();
            q.push_back(APB_DATA_W'(RDF_DEPTH + k));
            pop_beat(3'd0, d, d[0], "t4_wrap", 1'b1, APB_DATA_W'(RDF_DEPTH + k));
            check_eq("t4_count_steady", 64'(cnt_of(0)), 64'(RDF_DEPTH - 1));
        end

        // Presented beat held stable under back-pressure; a second request is ignored.
        write_beat(3'd6, 32'h77, 1'b1);
        write_beat(3'd6, 32'h78, 1'b0);
        rdf_data_req     = 1'b1;
        rdf_data_req_tag = 3'd6;
        @(negedge pclk);
        rdf_data_req = 1'b0;
        @(negedge pclk);
        for (int i = 0; i < 5; i++) begin
            check_eq("t5_hold_valid", 64'(rdf_data_valid), 64'd1);
            check_eq("t5_hold_data", 64'(rdf_data_out), 64'h77);
            check_eq("t5_hold_last", 64'(rdf_data_last), 64'd1);
            rdf_data_req = (i == 1);
            @(negedge pclk);
            rdf_data_req = 1'b0;
        end
`ifdef APB2AXI_RDF_CHK_EN
        check_eq("t5_err_req", 64'(err_req), 64'd1);
`endif
        rdf_data_ready = 1'b1;
        @(negedge pclk);
        rdf_data_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("t5_req_ignored", 64'(rdf_data_valid), 64'd0);
            @(negedge pclk);
        end
        check_eq("t5_count1", 64'(cnt_of(6)), 64'd1);
        pop_beat(3'd6, 32'h78, 1'b0, "t5_second");

        // Reset mid-presentation discards buffered beats immediately.
        write_beat(3'd4, 32'hC1, 1'b0);
        write_beat(3'd4, 32'hC2, 1'b0);
        write_beat(3'd4, 32'hC3, 1'b1);
        rdf_data_req     = 1'b1;
        rdf_data_req_tag = 3'd4;
        @(negedge pclk);
        rdf_data_req = 1'b0;
        @(negedge pclk);
        check_eq("t6_presenting", 64'(rdf_data_valid), 64'd1);
        wr_tag = 3'd4;
        #2;
        presetn = 1'b0;
        #1;
        check_eq("t6_valid_cleared", 64'(rdf_data_valid), 64'd0);
        check_eq("t6_data_cleared", 64'(rdf_data_out), 64'd0);
        check_eq("t6_counts_cleared", 64'(tag_count), 64'd0);
        check_eq("t6_wr_ready", 64'(wr_ready), 64'd1);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        rdf_data_req     = 1'b1;
        rdf_data_req_tag = 3'd4;
        @(negedge pclk);
        rdf_data_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("t6_waits_new", 64'(rdf_data_valid), 64'd0);
            @(negedge pclk);
        end
        write_beat(3'd4, 32'h99, 1'b1);
        @(negedge pclk);
        check_eq("t6_new_valid", 64'(rdf_data_valid), 64'd1);
        check_eq("t6_new_data", 64'(rdf_data_out), 64'h99);
        check_eq("t6_new_last", 64'(rdf_data_last), 64'd1);
        rdf_data_ready = 1'b1;
        @(negedge pclk);
        rdf_data_ready = 1'b0;
        check_eq("t6_final_empty", 64'(tag_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
